sme_driver: RTL and testbench

- Host-side sequencer for the string-match engine (SME) interface: collects a job (optional string, mandatory pattern) from an upstream byte stream, then plays it onto the SME char bus (chardata/isstring/ispattern) with the engine's strict contiguity rules.
- Waits for the engine's valid pulse, captures match/match_index and returns the result upstream through a valid/ready handshake.
- Sits between the test/command front-end and SME; one job in flight at a time.

---
 rtl/sme_driver.sv | 214 +++++++++++++++++++++
 tb/tb_sme_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sme_driver.sv
// sme_driver: host-side sequencer for the string-match engine (SME).
// Collects one job (optional string, mandatory pattern) from an upstream
// byte stream, replays it onto the SME char bus with no gaps, waits for the
// engine's result strobe (or times out) and hands the result upstream.
//
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   in_valid/in_ready           upstream char handshake (ready only in COLLECT)
//   in_data, in_kind, in_last   char byte, 0=string/1=pattern, last char of job
//   chardata/isstring/ispattern registered SME char bus
//   sme_valid/sme_match/sme_index  SME result strobe and payload
//   res_valid/res_ready         result handshake
//   res_match/res_index/res_err captured result, error flag
//   busy                        high whenever not collecting
module sme_driver #(
  parameter int STR_MAX = 32,
  parameter int PTN_MAX = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_err,
  output logic       busy
);

  localparam int SW = $clog2(STR_MAX);
  localparam int PW = $clog2(PTN_MAX);

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_SEND_STR,
    ST_SEND_PTN,
    ST_WAIT,
    ST_RESULT
  } state_t;

  state_t      state, next;

  logic [7:0]  str_buf [STR_MAX];
  logic [7:0]  ptn_buf [PTN_MAX];
  logic [5:0]  str_cnt;
  logic [3:0]  ptn_cnt;
  logic        err;
  logic        str_seen;   // a string char has arrived in the current job
  logic [5:0]  idx;        // position of the char currently on the SME bus
  logic [7:0]  tmo;

  logic        hs, str_hs, ptn_hs;
  logic [5:0]  str_wr;
  logic        str_full, ptn_full;
  logic [5:0]  str_cnt_n;
  logic [3:0]  ptn_cnt_n;
  logic        err_n;
  logic        job_str;
  logic [7:0]  str_first, ptn_first;
  logic [7:0]  chr_d;
  logic        isstr_d, isptn_d;
  logic [5:0]  idx_d;

  assign in_ready  = (state == ST_COLLECT);
  assign busy      = (state != ST_COLLECT);
  assign res_valid = (state == ST_RESULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_COLLECT;
    else       state <= next;
  end

  always_comb begin
    hs     = in_valid && (state == ST_COLLECT);
    str_hs = hs && !in_kind;
    ptn_hs = hs && in_kind;

    // The string held from an earlier job is overwritten from slot 0 as soon
    // as the new job delivers its first string char.
    str_wr    = str_seen ? str_cnt : '0;
    str_full  = (str_wr == 6'(STR_MAX));
    ptn_full  = (ptn_cnt == 4'(PTN_MAX));
    str_cnt_n = str_hs ? (str_full ? str_wr : str_wr + 6'd1) : str_cnt;
    ptn_cnt_n = (ptn_hs && !ptn_full) ? ptn_cnt + 4'd1 : ptn_cnt;
    err_n     = err || (str_hs && str_full) || (ptn_hs && ptn_full);
    job_str   = str_seen || str_hs;

    // The first SME char leaves on the in_last edge, so a char written on
    // that same edge has to bypass its buffer.
    str_first = (str_hs && (str_wr == 6'd0)) ? in_data : str_buf[0];
    ptn_first = (ptn_hs && (ptn_cnt == 4'd0)) ? in_data : ptn_buf[0];

    next    = state;
    chr_d   = '0;
    isstr_d = 1'b0;
    isptn_d = 1'b0;
    idx_d   = '0;

    case (state)
      ST_COLLECT: begin
        if (hs && in_last) begin
          if (err_n || (ptn_cnt_n == 4'd0)) begin
            next = ST_RESULT;
          end else if (job_str) begin
            next    = ST_SEND_STR;
            isstr_d = 1'b1;
            chr_d   = str_first;
          end else begin
            next    = ST_SEND_PTN;
            isptn_d = 1'b1;
            chr_d   = ptn_first;
          end
        end
      end
      ST_SEND_STR: begin
        if (idx == str_cnt - 6'd1) begin
          next    = ST_SEND_PTN;
          isptn_d = 1'b1;
          chr_d   = ptn_buf[0];
        end else begin
          idx_d   = idx + 6'd1;
          isstr_d = 1'b1;
          chr_d   = str_buf[idx_d[SW-1:0]];
        end
      end
      ST_SEND_PTN: begin
        if (idx == 6'(ptn_cnt) - 6'd1) begin
          next = ST_WAIT;
        end else begin
          idx_d   = idx + 6'd1;
          isptn_d = 1'b1;
          chr_d   = ptn_buf[idx_d[PW-1:0]];
        end
      end
      ST_WAIT: begin
        if (sme_valid || (tmo == 8'(TIMEOUT - 1))) next = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ready) next = ST_COLLECT;
      end
      default: next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STR_MAX; i++) str_buf[i] <= '0;
      for (int unsigned i = 0; i < PTN_MAX; i++) ptn_buf[i] <= '0;
      str_cnt   <= '0;
      ptn_cnt   <= '0;
      err       <= 1'b0;
      str_seen  <= 1'b0;
      idx       <= '0;
      tmo       <= '0;
      chardata  <= '0;
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      res_match <= 1'b0;
      res_index <= '0;
      res_err   <= 1'b0;
    end else begin
      chardata  <= chr_d;
      isstring  <= isstr_d;
      ispattern <= isptn_d;
      idx       <= idx_d;
      // Zero everywhere outside WAIT, so it starts at 0 on WAIT entry.
      tmo       <= (state == ST_WAIT) ? tmo + 8'd1 : '0;

      if (state == ST_COLLECT) begin
        if (str_hs && !str_full) str_buf[str_wr[SW-1:0]] <= in_data;
        if (ptn_hs && !ptn_full) ptn_buf[ptn_cnt[PW-1:0]] <= in_data;
        str_cnt <= str_cnt_n;
        ptn_cnt <= ptn_cnt_n;
        err     <= err_n;
        if (str_hs) str_seen <= 1'b1;
        if (next == ST_RESULT) begin
          res_err   <= 1'b1;
          res_match <= 1'b0;
          res_index <= '0;
        end
      end

      if (state == ST_WAIT) begin
        if (sme_valid) begin
          res_match <= sme_match;
          res_index <= sme_index;
          res_err   <= 1'b0;
        end else if (next == ST_RESULT) begin
          res_match <= 1'b0;
          res_index <= '0;
          res_err   <= 1'b1;
        end
      end

      if ((state == ST_RESULT) && res_ready) begin
        ptn_cnt  <= '0;
        err      <= 1'b0;
        str_seen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sme_driver.sv
// tb_sme_driver: directed self-checking bench for sme_driver with a
// hand-driven SME result model.
module tb_sme_driver;

  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_kind, in_last;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       sme_valid, sme_match;
  logic [4:0] sme_index;
  logic       res_valid, res_ready, res_match, res_err, busy;
  logic [4:0] res_index;

  int checks = 0;
  int failures = 0;
  int n_str, n_ptn;
  logic [7:0] trace[$];
  logic [7:0] expq[$];

  sme_driver #(.STR_MAX(32), .PTN_MAX(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_kind(in_kind), .in_last(in_last),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
    .res_index(res_index), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic kind, input logic [7:0] d, input logic last);
    int w = 0;
    in_valid = 1'b1; in_kind = kind; in_data = d; in_last = last;
    while (!in_ready && w < 50) begin step(); w++; end
    if (!in_ready) check_eq("in_ready_wait", in_ready, 1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Records SME bus traffic from the first cycle after in_last up to the
  // first idle cycle after the pattern, then optionally answers like SME.
  task automatic play(input string tag, input int exp_s, input int exp_p,
                      input bit reply, input logic m, input logic [4:0] ix);
    bit seen_p = 0, prev_s = 0, prev_p = 0, done = 0;
    int bad = 0;
    n_str = 0; n_ptn = 0; trace.delete();
    check_eq({tag, "_latency"}, {31'd0, isstring | ispattern}, 1);
    for (int i = 0; i < 80 && !done; i++) begin
      if (isstring && ispattern) bad++;
      if (isstring) begin
        if (seen_p || (n_str > 0 && !prev_s)) bad++;
        n_str++; trace.push_back(chardata);
      end else if (ispattern) begin
        if ((n_ptn > 0 && !prev_p) || (n_str > 0 && n_ptn == 0 && !prev_s)) bad++;
        seen_p = 1; n_ptn++; trace.push_back(chardata);
      end else if (seen_p) begin
        done = 1;
      end
      prev_s = isstring; prev_p = ispattern;
      if (!done) step();
    end
    check_eq({tag, "_contiguity"}, bad, 0);
    check_eq({tag, "_wait_entered"}, {31'd0, done}, 1);
    check_eq({tag, "_idle_chardata"}, {24'd0, chardata}, 0);
    check_eq({tag, "_nstr"}, n_str, exp_s);
    check_eq({tag, "_nptn"}, n_ptn, exp_p);
    for (int i = 0; i < expq.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i),
               (i < trace.size()) ? {24'd0, trace[i]} : 32'hFFFF_FFFF, {24'd0, expq[i]});
    if (reply) begin
      sme_valid = 1'b1; sme_match = m; sme_index = ix;
      step();
      sme_valid = 1'b0; sme_match = 1'b0; sme_index = '0;
    end
  endtask

  task automatic check_res(input string tag, input logic m, input logic [4:0] ix, input logic e);
    check_eq({tag, "_res_valid"}, {31'd0, res_valid}, 1);
    check_eq({tag, "_res_match"}, {31'd0, res_match}, {31'd0, m});
    check_eq({tag, "_res_index"}, {27'd0, res_index}, {27'd0, ix});
    check_eq({tag, "_res_err"}, {31'd0, res_err}, {31'd0, e});
    check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 1);
  endtask

  task automatic take_result(input string tag);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check_eq({tag, "_released"}, {31'd0, res_valid}, 0);
    check_eq({tag, "_ready_again"}, {31'd0, in_ready}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_hold, early;
    reset = 1'b1;
    in_valid = 0; in_kind = 0; in_last = 0; in_data = '0;
    sme_valid = 0; sme_match = 0; sme_index = '0; res_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();

    check_eq("rst_in_ready", {31'd0, in_ready}, 1);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_res_valid", {31'd0, res_valid}, 0);
    check_eq("rst_bus", {22'd0, isstring, ispattern, chardata}, 0);
    check_eq("rst_res", {25'd0, res_match, res_err, res_index}, 0);

    // Job 1: string "ab cd", pattern "cd", kinds interleaved upstream.
    send_char(0, 8'h61, 0);
    send_char(0, 8'h62, 0);
    send_char(1, 8'h63, 0);
    send_char(0, 8'h20, 0);
    send_char(0, 8'h63, 0);
    send_char(0, 8'h64, 0);
    send_char(1, 8'h64, 1);
    expq = '{8'h61, 8'h62, 8'h20, 8'h63, 8'h64, 8'h63, 8'h64};
    play("job1", 5, 2, 1, 1'b1, 5'd3);
    check_res("job1", 1'b1, 5'd3, 1'b0);

    // Result held 10 cycles with a stray SME strobe that must be ignored.
    bad_hold = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin sme_valid = 1; sme_match = 0; sme_index = 5'd7; end
      if (k == 5) begin sme_valid = 0; sme_index = '0; end
      step();
      if (!res_valid || !res_match || res_index != 5'd3 || res_err || in_ready) bad_hold++;
    end
    check_eq("hold_stable", bad_hold, 0);
    take_result("job1");

    // Job 2: pattern-only "^a", engine reports no match.
    send_char(1, 8'h5E, 0);
    send_char(1, 8'h61, 1);
    expq = '{8'h5E, 8'h61};
    play("job2", 0, 2, 1, 1'b0, 5'd0);
    check_res("job2", 1'b0, 5'd0, 1'b0);
    take_result("job2");

    // Job 3: 33 string chars overflow the buffer.
    for (int k = 0; k < 33; k++) send_char(0, 8'(8'h41 + k), 0);
    send_char(1, 8'h41, 1);
    check_eq("ovf_no_traffic", {30'd0, isstring, ispattern}, 0);
    check_res("ovf", 1'b0, 5'd0, 1'b1);
    take_result("ovf");

    // Job 4: no pattern chars at all.
    send_char(0, 8'h78, 1);
    check_eq("noptn_no_traffic", {30'd0, isstring, ispattern}, 0);
    check_res("noptn", 1'b0, 5'd0, 1'b1);
    take_result("noptn");

    // Job 5: engine never answers.
    send_char(0, 8'h71, 0);
    send_char(1, 8'h71, 1);
    expq = '{8'h71, 8'h71};
    play("tmo", 1, 1, 0, 1'b0, 5'd0);
    early = 0;
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      if (res_valid) early++;
    end
    check_eq("tmo_early", early, 0);
    step();
    check_res("tmo", 1'b0, 5'd0, 1'b1);
    take_result("tmo");

    // Job 6: normal job after the timeout.
    send_char(1, 8'h7A, 1);
    expq = '{8'h7A};
    play("after_tmo", 0, 1, 1, 1'b1, 5'd9);
    check_res("after_tmo", 1'b1, 5'd9, 1'b0);
    take_result("after_tmo");

    // Job 7: reset lands in the middle of the string phase.
    send_char(0, 8'h61, 0);
    send_char(0, 8'h62, 0);
    send_char(0, 8'h63, 0);
    send_char(1, 8'h62, 1);
    check_eq("rst_mid_sending", {31'd0, isstring}, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_bus", {30'd0, isstring, ispattern}, 0);
    check_eq("rst_mid_res_valid", {31'd0, res_valid}, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_eq("rst_mid_in_ready", {31'd0, in_ready}, 1);
    check_eq("rst_mid_idle", {30'd0, isstring, ispattern}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
